// File: rtl/fifo_multich_pkg.sv
// Shared widths and types for the multichannel FIFO bank with registered read select.
// Optional occupancy outputs are enabled by FIFO_MULTICH_RDSEL_OCCUPANCY_EN.
package fifo_multich_pkg;

    localparam int unsigned CHANNEL_CNT_DFLT   = 5;
    localparam int unsigned CHANNEL_DEPTH_DFLT = 1024;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int unsigned sel_width(input int unsigned cnt);
        return (cnt > 1) ? $clog2(cnt) : 1;
    endfunction

    localparam int unsigned PTR_W = ptr_width(CHANNEL_DEPTH_DFLT);
    localparam int unsigned SEL_W = sel_width(CHANNEL_CNT_DFLT);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [SEL_W-1:0] chsel_t;

endpackage

// File: rtl/fifo_multich_chbuf.sv
// One channel of the FIFO bank: RAM, wrap-bit pointers, registered ready, sticky overflow.
// Exposes post-edge head/empty so the top can register read outputs (FIFO_MULTICH_RDSEL_OCCUPANCY_EN adds occupancy).
module fifo_multich_chbuf
    import fifo_multich_pkg::*;
#(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned DEPTH = 1024,
    localparam int unsigned PW    = ptr_width(DEPTH)
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    output logic             overflow,
    input  logic             rd_pop,
    output logic             empty_nxt,
    output logic [WIDTH-1:0] head_nxt
`ifdef FIFO_MULTICH_RDSEL_OCCUPANCY_EN
    ,
    output logic [PW-1:0]    count_nxt,
    output logic             almost_full
`endif
);

    localparam int unsigned AW = PW - 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             ready_q, ready_d;
    logic             ovf_q, ovf_d;
    logic             empty_q, wr_fire, pop_fire;
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_comb begin
        empty_q  = (wr_ptr_q == rd_ptr_q);
        wr_fire  = wr_valid && ready_q;
        pop_fire = rd_pop && !empty_q;
        wr_ptr_d = wr_ptr_q + PW'(wr_fire);
        rd_ptr_d = rd_ptr_q + PW'(pop_fire);
        ready_d  = !((wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]));
        ovf_d    = ovf_q || (wr_valid && !ready_q);
        empty_nxt = (wr_ptr_d == rd_ptr_d);
        // The entry written this edge is not in the RAM yet; bypass it when it becomes the head.
        if (wr_fire && (rd_ptr_d == wr_ptr_q)) begin
            head_nxt = wr_data;
        end else begin
            head_nxt = mem_q[rd_ptr_d[AW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ready_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ready_q  <= ready_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    assign wr_ready = ready_q;
    assign overflow = ovf_q;

`ifdef FIFO_MULTICH_RDSEL_OCCUPANCY_EN
    logic [PW-1:0] occ_q;

    always_comb begin
        occ_q       = wr_ptr_q - rd_ptr_q;
        count_nxt   = wr_ptr_d - rd_ptr_d;
        almost_full = (occ_q >= PW'(DEPTH - 4));
    end
`endif

endmodule

// File: rtl/fifo_multich_rdsel.sv
// Multichannel FIFO bank with a SEL_LATENCY-deep read-select pipeline and registered FWFT read port.
// Define FIFO_MULTICH_RDSEL_OCCUPANCY_EN for o_rd_count and o_wr_almost_full.
module fifo_multich_rdsel
    import fifo_multich_pkg::*;
#(
    parameter  int unsigned CHANNEL_WIDTH = 32,
    parameter  int unsigned CHANNEL_CNT   = 5,
    parameter  int unsigned CHANNEL_DEPTH = 1024,
    parameter  int unsigned SEL_LATENCY   = 2,
    localparam int unsigned CH_SEL_W      = sel_width(CHANNEL_CNT),
    localparam int unsigned CH_PTR_W      = ptr_width(CHANNEL_DEPTH)
)(
    input  logic                               clk,
    input  logic                               rst,
    input  logic [CHANNEL_CNT-1:0]             i_wr_valid,
    input  logic [CHANNEL_CNT*CHANNEL_WIDTH-1:0] i_wr_data,
    output logic [CHANNEL_CNT-1:0]             o_wr_ready,
    output logic [CHANNEL_CNT-1:0]             o_overflow,
    input  logic [CH_SEL_W-1:0]                i_rd_select,
    output logic [CH_SEL_W-1:0]                o_rd_select,
    input  logic                               i_rd_en,
    output logic                               o_rd_valid,
    output logic [CHANNEL_WIDTH-1:0]           o_rd_data
`ifdef FIFO_MULTICH_RDSEL_OCCUPANCY_EN
    ,
    output logic [CH_PTR_W-1:0]                o_rd_count,
    output logic [CHANNEL_CNT-1:0]             o_wr_almost_full
`endif
);

    logic [CH_SEL_W-1:0]      sel_pipe_q [SEL_LATENCY];
    logic [CH_SEL_W-1:0]      sel_pipe_d [SEL_LATENCY];
    logic [CH_SEL_W-1:0]      sel_q, sel_d;
    logic [CHANNEL_CNT-1:0]   ch_pop;
    logic [CHANNEL_CNT-1:0]   ch_empty_nxt;
    logic [CHANNEL_WIDTH-1:0] ch_head_nxt [CHANNEL_CNT];
    logic                     rd_valid_q, rd_valid_d;
    logic [CHANNEL_WIDTH-1:0] rd_data_q, rd_data_d;
`ifdef FIFO_MULTICH_RDSEL_OCCUPANCY_EN
    logic [CH_PTR_W-1:0]      ch_count_nxt [CHANNEL_CNT];
    logic [CH_PTR_W-1:0]      rd_count_q, rd_count_d;
`endif

    // The last pipeline stage is the active select; it refuses out-of-range channel numbers.
    always_comb begin
        sel_pipe_d[0] = i_rd_select;
        for (int unsigned k = 1; k < SEL_LATENCY; k++) begin
            sel_pipe_d[k] = sel_pipe_q[k-1];
        end
        if (32'(sel_pipe_d[SEL_LATENCY-1]) >= CHANNEL_CNT) begin
            sel_pipe_d[SEL_LATENCY-1] = sel_pipe_q[SEL_LATENCY-1];
        end
        sel_q = sel_pipe_q[SEL_LATENCY-1];
        sel_d = sel_pipe_d[SEL_LATENCY-1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 0; k < SEL_LATENCY; k++) begin
                sel_pipe_q[k] <= '0;
            end
        end else begin
            sel_pipe_q <= sel_pipe_d;
        end
    end

    for (genvar g = 0; g < CHANNEL_CNT; g++) begin : g_ch
        fifo_multich_chbuf #(
            .WIDTH (CHANNEL_WIDTH),
            .DEPTH (CHANNEL_DEPTH)
        ) u_chbuf (
            .clk         (clk),
            .rst         (rst),
            .wr_valid    (i_wr_valid[g]),
            .wr_data     (i_wr_data[g*CHANNEL_WIDTH +: CHANNEL_WIDTH]),
            .wr_ready    (o_wr_ready[g]),
            .overflow    (o_overflow[g]),
            .rd_pop      (ch_pop[g]),
            .empty_nxt   (ch_empty_nxt[g]),
            .head_nxt    (ch_head_nxt[g])
`ifdef FIFO_MULTICH_RDSEL_OCCUPANCY_EN
            ,
            .count_nxt   (ch_count_nxt[g]),
            .almost_full (o_wr_almost_full[g])
`endif
        );
    end

    // Pops follow the select active at this edge; outputs follow the select active after it.
    always_comb begin
        ch_pop     = '0;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
`ifdef FIFO_MULTICH_RDSEL_OCCUPANCY_EN
        rd_count_d = '0;
`endif
        for (int unsigned i = 0; i < CHANNEL_CNT; i++) begin
            if (sel_q == CH_SEL_W'(i)) begin
                ch_pop[i] = i_rd_en;
            end
            if (sel_d == CH_SEL_W'(i)) begin
                rd_valid_d = !ch_empty_nxt[i];
                if (!ch_empty_nxt[i]) begin
                    rd_data_d = ch_head_nxt[i];
                end
`ifdef FIFO_MULTICH_RDSEL_OCCUPANCY_EN
                rd_count_d = ch_count_nxt[i];
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
`ifdef FIFO_MULTICH_RDSEL_OCCUPANCY_EN
            rd_count_q <= '0;
`endif
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
`ifdef FIFO_MULTICH_RDSEL_OCCUPANCY_EN
            rd_count_q <= rd_count_d;
`endif
        end
    end

    assign o_rd_select = sel_q;
    assign o_rd_valid  = rd_valid_q;
    assign o_rd_data   = rd_data_q;
`ifdef FIFO_MULTICH_RDSEL_OCCUPANCY_EN
    assign o_rd_count  = rd_count_q;
`endif

endmodule
